riscv_alu_arbiter: RTL

RISCV_ALU_ARBITER -- requirements
Module: riscv_alu_arbiter

---
 rtl/riscv_alu_arbiter_if.sv | 68 ++++++
 rtl/riscv_alu_arbiter.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/riscv_alu_arbiter_if.sv
// Bundle between two ALU requesters, the arbiter and one shared combinational ALU.
// The slave modport is the arbiter's view; the master modport is the view of
// everything around it (both requesters plus the ALU).
interface riscv_alu_arbiter_if;
   // Requester 0 request channel
   logic        req0_val;
   logic        req0_rdy;
   logic        req0_dw;
   logic [3:0]  req0_fn;
   logic [5:0]  req0_shamt;
   logic [63:0] req0_in1;
   logic [63:0] req0_in2;
   // Requester 1 request channel
   logic        req1_val;
   logic        req1_rdy;
   logic        req1_dw;
   logic [3:0]  req1_fn;
   logic [5:0]  req1_shamt;
   logic [63:0] req1_in1;
   logic [63:0] req1_in2;
   // Requester 0 response channel
   logic        resp0_val;
   logic        resp0_rdy;
   logic [63:0] resp0_data;
   logic        resp0_lt;
   logic        resp0_ltu;
   // Requester 1 response channel
   logic        resp1_val;
   logic        resp1_rdy;
   logic [63:0] resp1_data;
   logic        resp1_lt;
   logic        resp1_ltu;
   // Shared ALU
   logic        alu_dw;
   logic [3:0]  alu_fn;
   logic [5:0]  alu_shamt;
   logic [63:0] alu_in1;
   logic [63:0] alu_in2;
   logic [63:0] alu_out;
   logic        alu_lt;
   logic        alu_ltu;

   modport slave (
      input  req0_val, req0_dw, req0_fn, req0_shamt, req0_in1, req0_in2,
      output req0_rdy,
      input  req1_val, req1_dw, req1_fn, req1_shamt, req1_in1, req1_in2,
      output req1_rdy,
      output resp0_val, resp0_data, resp0_lt, resp0_ltu,
      input  resp0_rdy,
      output resp1_val, resp1_data, resp1_lt, resp1_ltu,
      input  resp1_rdy,
      output alu_dw, alu_fn, alu_shamt, alu_in1, alu_in2,
      input  alu_out, alu_lt, alu_ltu
   );

   modport master (
      output req0_val, req0_dw, req0_fn, req0_shamt, req0_in1, req0_in2,
      input  req0_rdy,
      output req1_val, req1_dw, req1_fn, req1_shamt, req1_in1, req1_in2,
      input  req1_rdy,
      input  resp0_val, resp0_data, resp0_lt, resp0_ltu,
      output resp0_rdy,
      input  resp1_val, resp1_data, resp1_lt, resp1_ltu,
      output resp1_rdy,
      input  alu_dw, alu_fn, alu_shamt, alu_in1, alu_in2,
      output alu_out, alu_lt, alu_ltu
   );
endinterface

// File: rtl/riscv_alu_arbiter.sv
// Two-requester arbiter in front of one shared combinational 64-bit ALU.
// Pipeline: accept (cycle N) -> issue register drives the ALU (N+1) ->
// per-requester response buffer valid from N+2. One credit per requester
// guarantees its response buffer is free when its operation completes, so the
// issue stage never stalls.
// Build option: define RISCV_ALU_ARB_FIXED_PRIO_EN to make requester 0 win every
// tie (the round-robin pointer is then removed); default is round-robin.
module riscv_alu_arbiter (
   input  logic               clk,
   input  logic               reset,
   riscv_alu_arbiter_if.slave bus
);

   logic [1:0]  w_req_val;
   logic [1:0]  w_resp_rdy;
   logic [1:0]  w_resp_hs;
   logic [1:0]  w_free;
   logic [1:0]  w_elig;
   logic [1:0]  w_rdy;
   logic [1:0]  w_grant;
   logic [1:0]  w_fill;
   logic        w_accept;
   logic        w_acc_id;
   logic        w_prefer1;

   logic        w_sel_dw;
   logic [3:0]  w_sel_fn;
   logic [5:0]  w_sel_shamt;
   logic [63:0] w_sel_in1;
   logic [63:0] w_sel_in2;

   logic [1:0]  r_credit;
   logic        r_iss_val;
   logic        r_iss_id;
   logic        r_iss_dw;
   logic [3:0]  r_iss_fn;
   logic [5:0]  r_iss_shamt;
   logic [63:0] r_iss_in1;
   logic [63:0] r_iss_in2;

   logic [1:0]        r_resp_val;
   logic [1:0][63:0]  r_resp_data;
   logic [1:0]        r_resp_lt;
   logic [1:0]        r_resp_ltu;

   assign w_req_val  = {bus.req1_val, bus.req0_val};
   assign w_resp_rdy = {bus.resp1_rdy, bus.resp0_rdy};
   // A credit returned by this cycle's response handshake can be reused at once.
   assign w_resp_hs  = r_resp_val & w_resp_rdy;
   assign w_free     = ~r_credit | w_resp_hs;
   assign w_elig     = w_req_val & w_free;

`ifdef RISCV_ALU_ARB_FIXED_PRIO_EN
   assign w_prefer1 = 1'b0;
`else
   logic r_ptr;

   assign w_prefer1 = r_ptr;

   // Round-robin pointer: after a grant the other requester is preferred.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_ptr <= 1'b0;
      end else if (w_accept) begin
         r_ptr <= ~w_acc_id;
      end else begin
         r_ptr <= r_ptr;
      end
   end
`endif

   // Ready per requester, built only from its own credit and the other side's
   // eligibility so that rdy never depends on the same requester's val.
   always_comb begin
      w_rdy = 2'b00;
      if (reset) begin
         w_rdy = 2'b00;
      end else begin
         w_rdy[0] = w_free[0] & (~w_prefer1 | ~w_elig[1]);
         w_rdy[1] = w_free[1] & ( w_prefer1 | ~w_elig[0]);
      end
   end

   assign w_grant  = w_rdy & w_req_val;
   assign w_accept = |w_grant;
   assign w_acc_id = w_grant[1];

   // Select the operation of the granted requester.
   always_comb begin
      w_sel_dw    = bus.req0_dw;
      w_sel_fn    = bus.req0_fn;
      w_sel_shamt = bus.req0_shamt;
      w_sel_in1   = bus.req0_in1;
      w_sel_in2   = bus.req0_in2;
      if (w_acc_id) begin
         w_sel_dw    = bus.req1_dw;
         w_sel_fn    = bus.req1_fn;
         w_sel_shamt = bus.req1_shamt;
         w_sel_in1   = bus.req1_in1;
         w_sel_in2   = bus.req1_in2;
      end else begin
         w_sel_dw    = bus.req0_dw;
         w_sel_fn    = bus.req0_fn;
         w_sel_shamt = bus.req0_shamt;
         w_sel_in1   = bus.req0_in1;
         w_sel_in2   = bus.req0_in2;
      end
   end

   // Credits: taken on accept, returned on response handshake (accept wins a tie).
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_credit <= 2'b00;
      end else begin
         r_credit <= w_grant | (r_credit & ~w_resp_hs);
      end
   end

   // Issue stage control: valid for exactly the cycle after an accept.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_iss_val <= 1'b0;
         r_iss_id  <= 1'b0;
      end else begin
         r_iss_val <= w_accept;
         if (w_accept) begin
            r_iss_id <= w_acc_id;
         end
      end
   end

   // Issue stage operands; only loaded on accept so the ALU inputs hold when idle.
   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_iss_dw    <= w_sel_dw;
         r_iss_fn    <= w_sel_fn;
         r_iss_shamt <= w_sel_shamt;
         r_iss_in1   <= w_sel_in1;
         r_iss_in2   <= w_sel_in2;
      end
   end

   assign w_fill = {r_iss_val & r_iss_id, r_iss_val & ~r_iss_id};

   // Response valids: set by the completing operation, cleared by handshake.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_resp_val <= 2'b00;
      end else begin
         r_resp_val <= w_fill | (r_resp_val & ~w_resp_hs);
      end
   end

   // Response payload capture from the shared ALU for the owning requester.
   always_ff @(posedge clk) begin
      if (w_fill[0]) begin
         r_resp_data[0] <= bus.alu_out;
         r_resp_lt[0]   <= bus.alu_lt;
         r_resp_ltu[0]  <= bus.alu_ltu;
      end
      if (w_fill[1]) begin
         r_resp_data[1] <= bus.alu_out;
         r_resp_lt[1]   <= bus.alu_lt;
         r_resp_ltu[1]  <= bus.alu_ltu;
      end
   end

   assign bus.req0_rdy   = w_rdy[0];
   assign bus.req1_rdy   = w_rdy[1];

   assign bus.resp0_val  = r_resp_val[0];
   assign bus.resp0_data = r_resp_data[0];
   assign bus.resp0_lt   = r_resp_lt[0];
   assign bus.resp0_ltu  = r_resp_ltu[0];
   assign bus.resp1_val  = r_resp_val[1];
   assign bus.resp1_data = r_resp_data[1];
   assign bus.resp1_lt   = r_resp_lt[1];
   assign bus.resp1_ltu  = r_resp_ltu[1];

   assign bus.alu_dw     = r_iss_dw;
   assign bus.alu_fn     = r_iss_fn;
   assign bus.alu_shamt  = r_iss_shamt;
   assign bus.alu_in1    = r_iss_in1;
   assign bus.alu_in2    = r_iss_in2;

endmodule
